// File: rtl/subtractor_serial_n.sv
// Bit-serial N-bit subtractor: LSB-first borrow chain, one bit per clock.
// Flags and difference update together when the last bit is processed.
module subtractor_serial_n #(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         n_Reset,
  input  logic         Start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic [N-1:0] Diff,
  output logic         Bout,
  output logic         Zero,
  output logic         V,
  output logic         Busy,
  output logic         Done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic [N-1:0]   res;
  logic           br;
  logic [CW-1:0]  cnt;

  logic           ai;
  logic           bi;
  logic           d;
  logic           br_nxt;
  logic           last;
  logic [N-1:0]   res_nxt;

  // Operands shift right, so bit 0 is always the bit being processed
  always_comb begin
    ai      = a_r[0];
    bi      = b_r[0];
    d       = ai ^ bi ^ br;
    br_nxt  = (~ai & bi) | (~(ai ^ bi) & br);
    last    = (cnt == CW'(N - 1));
    res_nxt = (res >> 1) | (N'(d) << (N - 1));
  end

  always_ff @(posedge CLK or negedge n_Reset) begin
    if (!n_Reset) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      Diff  <= '0;
      Bout  <= 1'b0;
      Zero  <= 1'b0;
      V     <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            a_r   <= A;
            b_r   <= B;
            br    <= Bin;
            res   <= '0;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_r <= a_r >> 1;
          b_r <= b_r >> 1;
          br  <= br_nxt;
          res <= res_nxt;
          cnt <= cnt + CW'(1);
          // On the last bit, ai/bi are the operand sign bits
          if (last) begin
            Diff  <= res_nxt;
            Bout  <= br_nxt;
            Zero  <= (res_nxt == '0);
            V     <= (ai != bi) && (d != ai);
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subtractor_serial_n.sv
// Randomised self-checking bench for subtractor_serial_n.
// Reference model uses plain integer arithmetic.
module tb_subtractor_serial_n;

  localparam int N = 4;
  localparam int M = 1 << N;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic [N-1:0] diff;
  logic         bout;
  logic         zero;
  logic         v;
  logic         busy;
  logic         done;

  int checks;
  int failures;

  subtractor_serial_n #(.N(N)) dut (
    .CLK    (clk),
    .n_Reset(rst_n),
    .Start  (start),
    .A      (a),
    .B      (b),
    .Bin    (bin),
    .Diff   (diff),
    .Bout   (bout),
    .Zero   (zero),
    .V      (v),
    .Busy   (busy),
    .Done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int diff;
    int bout;
    int zero;
    int v;
  } ref_t;

  function automatic ref_t model(input int x, input int y, input int c);
    ref_t r;
    int sx;
    int sy;
    int sr;
    int u;
    u      = x - y - c;
    r.diff = ((u % M) + M) % M;
    r.bout = (u < 0) ? 1 : 0;
    r.zero = (r.diff == 0) ? 1 : 0;
    sx     = (x >= M / 2) ? x - M : x;
    sy     = (y >= M / 2) ? y - M : y;
    sr     = sx - sy - c;
    r.v    = (sr < -(M / 2) || sr > M / 2 - 1) ? 1 : 0;
    return r;
  endfunction

  task automatic chk_res(input string tag, input int x, input int y,
                         input int c);
    ref_t r;
    r = model(x, y, c);
    chk({tag, ".diff"}, 32'(diff), 32'(r.diff));
    chk({tag, ".bout"}, 32'(bout), 32'(r.bout));
    chk({tag, ".zero"}, 32'(zero), 32'(r.zero));
    chk({tag, ".v"},    32'(v),    32'(r.v));
  endtask

  // One operation; operands may be scrambled after capture
  task automatic do_op(input string tag, input int x, input int y,
                       input int c, input bit scramble, input bit full);
    int busy_n;
    int wait_n;
    bit both;
    bit held;
    logic [N-1:0] pd;
    pd = diff;
    @(negedge clk);
    a = N'(x); b = N'(y); bin = c[0]; start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    busy_n = 0;
    wait_n = 0;
    both   = 1'b0;
    held   = 1'b1;
    while (!done && wait_n < 3 * N + 4) begin
      if (busy) busy_n++;
      if (busy && done) both = 1'b1;
      if (diff !== pd) held = 1'b0;
      if (scramble) begin
        a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
      end
      @(negedge clk);
      wait_n++;
    end
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".res"}, 32'(busy_n == N ? 1 : 0) | 32'(busy_n << 4),
        32'(1) | 32'(N << 4));
    chk_res(tag, x, y, c);
    if (full) begin
      chk({tag, ".both"}, 32'(both), 32'd0);
      chk({tag, ".held"}, 32'(held), 32'd1);
      chk({tag, ".busyd"}, 32'(busy), 32'd0);
      @(negedge clk);
      chk({tag, ".pulse"}, 32'(done), 32'd0);
    end else begin
      @(negedge clk);
    end
  endtask

  initial begin
    int x;
    int y;
    int c;
    int d1;
    int d2;
    int k;
    ref_t r;
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    #3;
    chk("rst.diff", 32'(diff), 32'd0);
    chk("rst.flags", {28'd0, bout, zero, v, busy}, 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("v9m3", 9, 3, 0, 1'b0, 1'b1);
    do_op("v3m9", 3, 9, 0, 1'b0, 1'b1);
    do_op("v5m4b", 5, 4, 1, 1'b0, 1'b1);
    do_op("v0m0b", 0, 0, 1, 1'b0, 1'b1);
    do_op("scr", 12, 5, 1, 1'b1, 1'b1);

    // Start held high: back-to-back spacing of N+2 cycles
    @(negedge clk);
    a = 4'd11; b = 4'd6; bin = 1'b0; start = 1'b1;
    d1 = -1;
    d2 = -1;
    for (k = 1; k <= 2 * N + 6; k++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) begin
          d1 = k;
          chk_res("b2b1", 11, 6, 0);
        end else if (d2 < 0) begin
          d2 = k;
          chk_res("b2b2", 2, 13, 1);
          start = 1'b0;
        end
      end
      if (k == N + 2) begin
        a = 4'd2; b = 4'd13; bin = 1'b1;
      end else if (d2 < 0) begin
        a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
      end
    end
    start = 1'b0;
    chk("b2b.first", 32'(d1), 32'(N + 1));
    chk("b2b.space", 32'(d2 - d1), 32'(N + 2));
    @(negedge clk);

    // Reset in the 2nd RUN cycle abandons the operation
    do_op("pre", 9, 3, 0, 1'b0, 1'b0);
    @(negedge clk);
    a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid.busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid.diff", 32'(diff), 32'd0);
    chk("mid.flags", {27'd0, bout, zero, v, busy, done}, 32'd0);
    c = 0;
    for (k = 0; k < N + 3; k++) begin
      @(negedge clk);
      if (done) c++;
    end
    chk("mid.nodone", 32'(c), 32'd0);
    rst_n = 1'b1;
    do_op("post", 7, 2, 0, 1'b0, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      x = int'($urandom_range(M - 1, 0));
      y = int'($urandom_range(M - 1, 0));
      c = int'($urandom_range(1, 0));
      do_op("rnd", x, y, c, ($urandom_range(3, 0) == 0), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
